// File: rtl/fetch_stage.sv
// IF stage of the rv32i core: owns the PC, drives the imem address and fills the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds fetched/stalled performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH_WORDS = 4096
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        fault_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stalled_o
`endif
);

    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [31:0] DEPTH_LIMIT = 32'(IMEM_DEPTH_WORDS);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        ifid_fault_q, ifid_fault_d;
    logic        fetch_fault;

    assign fetch_fault = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= DEPTH_LIMIT);

    always_comb begin
        // NOTE: every _d gets a hold default first so no path can infer a latch.
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_fault_d = ifid_fault_q;
        if (redirect_i) begin
            // Flush the wrong-path fetch; a misaligned target faults on its own fetch.
            pc_d         = redirect_pc_i;
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
            ifid_fault_d = 1'b0;
        end else if (!stall_i) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = fetch_fault ? NOP : imem_instr_i;
            ifid_valid_d = 1'b1;
            ifid_fault_d = fetch_fault;
            pc_d         = pc_q + 32'd4;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            ifid_fault_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_fault_q <= ifid_fault_d;
        end
    end

    assign imem_pc_o = pc_q;
    assign pc_o      = ifid_pc_q;
    assign instr_o   = ifid_instr_q;
    assign valid_o   = ifid_valid_q;
    assign fault_o   = ifid_fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stalled_q, perf_stalled_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stalled_d = perf_stalled_q;
        if (!redirect_i && !stall_i && !fetch_fault) perf_fetched_d = perf_fetched_q + 32'd1;
        if (!redirect_i && stall_i)                  perf_stalled_d = perf_stalled_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_fetched_q <= 32'h0;
            perf_stalled_q <= 32'h0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalled_q <= perf_stalled_d;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_stalled_o = perf_stalled_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a per-cycle behavioural model queues the expected IF/ID
// contents and a negedge monitor compares them; reset behaviour is checked directly.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4096;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic [31:0] imem_pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] imem_pc, imem_instr;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out, instr_out;
    logic        valid_out, fault_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stalled;
`endif

    logic [31:0] mem [0:DEPTH-1];
    assign imem_instr = mem[imem_pc[13:2]];

    fetch_stage #(.RESET_PC(RESET_PC), .IMEM_DEPTH_WORDS(DEPTH)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .imem_pc_o(imem_pc), .imem_instr_i(imem_instr),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .pc_o(pc_out), .instr_o(instr_out), .valid_o(valid_out), .fault_o(fault_out)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched_o(perf_fetched), .perf_stalled_o(perf_stalled)
`endif
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    // Reference model state: architectural PC plus what IF/ID should hold.
    logic [31:0] m_pc, m_opc, m_instr;
    logic        m_valid, m_fault;
    int unsigned m_fetched, m_stalled;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_opc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
        m_fetched = 0; m_stalled = 0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_pc_o"},    pc_out, 32'h0);
        check({tag, "_instr_o"}, instr_out, NOP);
        check({tag, "_valid_o"}, {31'h0, valid_out}, 32'h0);
        check({tag, "_fault_o"}, {31'h0, fault_out}, 32'h0);
        check({tag, "_imem_pc"}, imem_pc, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        check({tag, "_perf_fetched"}, perf_fetched, 32'h0);
        check({tag, "_perf_stalled"}, perf_stalled, 32'h0);
`endif
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
        exp_t e;
        logic flt;
        #1;
        stall = st; redirect = rd; redirect_pc = tgt;
        if (rd) begin
            m_pc = tgt; m_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
        end else if (st) begin
            m_stalled++;
        end else begin
            flt = (m_pc % 4 != 0) || ((m_pc / 4) >= DEPTH);
            m_opc   = m_pc;
            m_instr = flt ? NOP : mem[m_pc[13:2]];
            m_valid = 1'b1;
            m_fault = flt;
            if (!flt) m_fetched++;
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_opc; e.instr = m_instr; e.valid = m_valid; e.fault = m_fault; e.imem_pc = m_pc;
        @(posedge clk);
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       rand_target = {18'h0, 12'($urandom_range(0, DEPTH - 1)), 2'b00};
            1:       rand_target = $urandom;
            2:       rand_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: rand_target = 32'h0000_3FF0 + 32'(4 * $urandom_range(0, 7));
        endcase
    endfunction

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic rd, st;
            rd = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 3) == 0);
            step(st, rd, rd ? rand_target() : $urandom);
        end
    endtask

    // Monitor: the IF/ID register presents a new value every cycle, bubble or not.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_o",      pc_out, e.pc);
                check("instr_o",   instr_out, e.instr);
                check("valid_o",   {31'h0, valid_out}, {31'h0, e.valid});
                check("fault_o",   {31'h0, fault_out}, {31'h0, e.fault});
                check("imem_pc_o", imem_pc, e.imem_pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0t expected < 200000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        model_reset();

        repeat (3) @(posedge clk);
        reset_checks("reset");
        @(negedge clk);
        rstn = 1'b1;
        #1;
        reset_checks("post_release");

        // Sequential fetch 0,4 then 3-cycle stall at pc_q=8, then resume.
        step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(0, 0, 0); step(0, 0, 0);

        // Redirect beats stall.
        step(1, 1, 32'h40); step(0, 0, 0); step(0, 0, 0);
        // Misaligned target faults on its own fetch.
        step(0, 1, 32'h42); step(0, 0, 0); step(0, 0, 0);
        // Last valid word, then out of range at 0x4000.
        step(0, 1, 32'h3FFC); step(0, 0, 0); step(0, 0, 0);
        // PC wraps past 0xFFFF_FFFC to 0.
        step(0, 1, 32'hFFFF_FFFC); step(0, 0, 0); step(0, 0, 0);

        random_steps(200);

`ifdef FETCH_PERF_CNT_EN
        @(negedge clk);
        check("perf_fetched", perf_fetched, 32'(m_fetched));
        check("perf_stalled", perf_stalled, 32'(m_stalled));
`endif

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        reset_checks("async_reset");
        stall = 1'b0; redirect = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        reset_checks("async_hold");
        @(negedge clk);
        rstn = 1'b1;

        // Perf directed run: 10 fetches, 2 stalls, 1 redirect from fresh reset.
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        step(1, 0, 0); step(1, 0, 0);
        step(0, 1, 32'h100);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        @(negedge clk);
        check("perf_fetched_10", perf_fetched, 32'd10);
        check("perf_stalled_2",  perf_stalled, 32'd2);
`endif

        random_steps(100);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
